// File: rtl/div_pipe.sv
// div_pipe: two-stage registered, handshaked signed/unsigned divider.
//
// Stage 1 captures the operands in sign-magnitude form (magnitudes, quotient
// sign, overflow flag). The combinational Division array divides the stage-1
// magnitudes. Stage 2 applies sign correction and flag generation to its
// result and registers it. Holds two beats; full backpressure.
//
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   in_valid / in_ready     operand handshake (in_ready combinational from out_ready)
//   op_a, op_b, is_signed   dividend, divisor, 1 = two's-complement divide
//   flush                   synchronous pipeline clear (DIV_PIPE_FLUSH_EN only)
//   out_valid / out_ready   result handshake
//   quotient                quotient truncated toward zero; all-ones on /0
//   has_remainder           nonzero remainder (0 on /0)
//   div_by_zero             divisor was 0
//   overflow                signed most-negative / -1
//
// Build option: define DIV_PIPE_FLUSH_EN to add the flush port.

module div_pipe #(
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [L-1:0] op_a,
    input  logic [L-1:0] op_b,
    input  logic         is_signed,
`ifdef DIV_PIPE_FLUSH_EN
    input  logic         flush,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [L-1:0] quotient,
    output logic         has_remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam logic [L-1:0] MOST_NEG = {1'b1, {(L-1){1'b0}}};

    logic flush_i;
`ifdef DIV_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, accept, s2_load;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv & ~flush_i;
    assign accept   = in_valid & in_ready;
    assign s2_load  = s1_valid & s2_adv & ~flush_i;
    assign out_valid = s2_valid;

    // ---------------- stage 1: sign-magnitude capture ----------------
    logic [L-1:0] mag_a, mag_b, mag_a_d, mag_b_d;
    logic         neg_q, ovf, neg_q_d, ovf_d;

    // Negation is modulo 2^L, so the most-negative value maps to itself and
    // still reads correctly as an unsigned magnitude.
    assign mag_a_d = (is_signed & op_a[L-1]) ? ('0 - op_a) : op_a;
    assign mag_b_d = (is_signed & op_b[L-1]) ? ('0 - op_b) : op_b;
    assign neg_q_d = is_signed & (op_a[L-1] ^ op_b[L-1]);
    assign ovf_d   = is_signed & (op_a == MOST_NEG) & (op_b == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            neg_q <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            mag_a <= mag_a_d;
            mag_b <= mag_b_d;
            neg_q <= neg_q_d;
            ovf   <= ovf_d;
        end
    end

    // ---------------- divide array ----------------
    logic [L-1:0] div_q;
    logic         div_rem, div_zero;

    Division #(L) u_div (
        .A            (mag_a),
        .B            (mag_b),
        .Q            (div_q),
        .HasRemainder (div_rem),
        .DivByZero    (div_zero)
    );

    // ---------------- stage 2: sign fix and flags ----------------
    // Overflow needs no special case: 0x8000/1 gives Q = 0x8000 with neg_q = 0.
    logic [L-1:0] q_fix;
    assign q_fix = div_zero ? '1 : (neg_q ? ('0 - div_q) : div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient      <= '0;
            has_remainder <= 1'b0;
            div_by_zero   <= 1'b0;
            overflow      <= 1'b0;
        end else if (s2_load) begin
            quotient      <= q_fix;
            has_remainder <= div_rem & ~div_zero;
            div_by_zero   <= div_zero;
            overflow      <= ovf;
        end
    end

endmodule

// Division: combinational unsigned restoring divider (ripple array).
//   A / B -> Q, HasRemainder = remainder nonzero, DivByZero = (B == 0).
module Division #(
    parameter int L = 16
) (
    input  logic [L-1:0] A,
    input  logic [L-1:0] B,
    output logic [L-1:0] Q,
    output logic         HasRemainder,
    output logic         DivByZero
);

    logic [L:0] rem;

    always_comb begin
        rem = '0;
        Q   = '0;
        for (int i = L - 1; i >= 0; i--) begin
            rem = {rem[L-1:0], A[i]};
            if (rem >= {1'b0, B}) begin
                rem  = rem - {1'b0, B};
                Q[i] = 1'b1;
            end
        end
        HasRemainder = |rem;
        DivByZero    = ~|B;
    end

endmodule

// File: doc/div_pipe.md
# div_pipe

Registered, handshaked wrapper around the combinational `Division` unit, turning it into a two-stage signed/unsigned divide pipeline for the ALU.
- Stage 1 captures operands and converts them to sign-magnitude form.
- Stage 2 applies sign correction and flag generation to the `Division` result, then registers it.
- Valid/ready handshakes on both sides provide one result per cycle with full backpressure.

## Interface
- `L`, 16, operand and quotient width in bits; passed to `Division #(L)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  block accepts the beat this cycle.
- `op_a`  in  L  dividend.
- `op_b`  in  L  divisor.
- `is_signed`  in  1  1 = two's-complement divide, 0 = unsigned.
- `out_valid`  out  1  result beat offered.
- `out_ready`  in  1  consumer takes the result this cycle.
- `quotient`  out  L  quotient, truncated toward zero.
- `has_remainder`  out  1  nonzero remainder.
- `div_by_zero`  out  1  `op_b` was 0.
- `overflow`  out  1  signed most-negative / -1.
- `flush`  in  1  synchronous pipeline clear; present only with `DIV_PIPE_FLUSH_EN`.

## Operation
- Stage 1 registers `s1_valid`, `mag_a`, `mag_b`, `neg_q` and `ovf`.
  - Magnitude: `mag_x = (is_signed & x[L-1]) ? -x : x`, taken modulo 2^L, so 0x8000 stays 0x8000.
  - `neg_q = is_signed & (a[L-1] ^ b[L-1])`.
  - `ovf = is_signed & (a == {1'b1,{L-1{0}}}) & (b == all-ones)`.
- `mag_a` and `mag_b` drive `Division.A` and `Division.B` combinationally.
- Stage 2 registers `s2_valid` and the outputs:
  - `quotient = div_by_zero ? all-ones : (neg_q ? -Q : Q)`.
  - `has_remainder = HasRemainder & ~div_by_zero`.
  - `div_by_zero = DivByZero`.
  - `overflow = ovf`. In the overflow case the quotient is 0x8000: `Q` = 0x8000 and `neg_q` = 0.
- Divide by zero always yields quotient all-ones, regardless of sign.
- Handshake:
  - `s2_adv = ~s2_valid | out_ready`.
  - `s1_adv = ~s1_valid | s2_adv`.
  - `in_ready = s1_adv`, which is combinational from `out_ready`.
- Transfers:
  - An input beat is accepted when `in_valid & in_ready`.
  - A result beat leaves when `out_valid & out_ready`.
  - Stage 2 loads from stage 1 when `s1_valid & s2_adv`.
- Payload registers update only on their stage's load. Outputs hold stable while `out_valid & ~out_ready`.
- `in_valid` may drop without a transfer; no state changes in that case.

## Timing
- Latency: 2 cycles from accept edge to `out_valid`. An operand accepted at edge N is visible at the outputs after edge N+1.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Capacity is 2 beats.
  - With `out_ready` low, `in_ready` drops once both stages are full.
  - It rises in the same cycle `out_ready` returns.
- Full pipeline with `out_ready` high and `in_valid` high:
  - the stage 2 output leaves,
  - stage 1 moves to stage 2,
  - the new beat enters stage 1,
  - all at the same edge.
- Reset (`rst_n` low, any time): `s1_valid`, `s2_valid`, `out_valid`, `quotient`, `has_remainder`, `div_by_zero` and `overflow` go to 0 immediately.
  - `in_ready` reads 1 during reset.
  - In-flight beats are discarded.
  - Operation resumes on the first edge after release.
- Critical path: stage 1 regs → `Division` ripple → negate → stage 2 regs. No other logic sits on it.

## Configuration
- `DIV_PIPE_FLUSH_EN` defined:
  - The `flush` port exists.
  - When `flush` is 1 at an edge, `s1_valid` and `s2_valid` clear to 0 and any concurrent input accept is dropped.
  - `in_ready` is forced to 0 while `flush` is high.
  - Payload registers are left unchanged.
- `DIV_PIPE_FLUSH_EN` undefined: no `flush` port, and the pipeline clears only via `rst_n`.

## Test plan
- Unsigned 100 / 7, `out_ready` = 1 → 2 cycles later `quotient` = 14, `has_remainder` = 1, other flags 0.
- Signed -7 / 2, i.e. 0xFFF9 / 0x0002 → `quotient` = 0xFFFD, `has_remainder` = 1. Signed 7 / -7 → 0xFFFF, `has_remainder` = 0.
- Signed 0x8000 / 0xFFFF → `quotient` = 0x8000, `overflow` = 1. Unsigned 0x8000 / 0xFFFF → 0, `has_remainder` = 1, `overflow` = 0.
- 0x1234 / 0 in both modes → `quotient` = 0xFFFF, `div_by_zero` = 1, `has_remainder` = 0.
- Backpressure: send 4 back-to-back beats with `out_ready` low for 5 cycles.
  - `in_ready` drops after 2 accepts.
  - The held output stays stable.
  - Releasing `out_ready` drains all 4 results in order, one per cycle.
- Pull `rst_n` low with 2 beats in flight → outputs 0 immediately, no stale result after release. With the macro on, `flush` at the same point → `out_valid` = 0 next cycle.
